// File: rtl/flex_pkg.sv
// Shared types and defaults for the flex_down_counter timer block.
package flex_pkg;

  localparam int unsigned DEFAULT_NUM_CNT_BITS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_t;

endpackage

// File: rtl/flex_down_counter.sv
// Loadable down-counter with terminal-count strobe, one-shot and auto-reload modes.
module flex_down_counter
  import flex_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = DEFAULT_NUM_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    zero_flag,
  output logic                    done_pulse,
  output logic                    busy
);

  localparam int unsigned W = NUM_CNT_BITS;

  cnt_state_t   state, state_nxt;
  logic [W-1:0] reload_reg, reload_nxt;
  logic [W-1:0] count_nxt;
  logic         done_nxt;
  logic         zero_nxt;
  logic         busy_nxt;

  // State, count and registered status outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      count_out  <= '0;
      reload_reg <= '0;
      zero_flag  <= 1'b1;
      done_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_out  <= count_nxt;
      reload_reg <= reload_nxt;
      zero_flag  <= zero_nxt;
      done_pulse <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state: clear > load > enabled decrement > hold
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_out;
    reload_nxt = reload_reg;
    done_nxt   = 1'b0;

    if (clear) begin
      count_nxt = '0;
      state_nxt = IDLE;
    end else if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          count_nxt = count_out;
        end
        RUN: begin
          if (count_enable) begin
            if (count_out == W'(1)) begin
              done_nxt = 1'b1;
              if (auto_reload && (reload_reg != '0)) begin
                count_nxt = reload_reg;
                state_nxt = RUN;
              end else begin
                count_nxt = '0;
                state_nxt = IDLE;
              end
            end else begin
              count_nxt = count_out - W'(1);
            end
          end
        end
        default: begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      endcase
    end

    // Status flags track the values being registered this edge
    zero_nxt = (count_nxt == '0);
    busy_nxt = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_flex_down_counter.sv
// Self-checking bench for flex_down_counter: directed scenarios plus randomized traffic vs a period model.
module tb_flex_down_counter;

  localparam int unsigned W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         count_enable;
  logic         auto_reload;
  logic [W-1:0] count_out;
  logic         zero_flag;
  logic         done_pulse;
  logic         busy;

  int checks;
  int passes;

  // Reference: remaining period and stored period as plain integers
  int m_count;
  int m_reload;
  bit m_done;

  logic [W+2:0] got;
  logic [W+2:0] exp;

  flex_down_counter #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .count_out    (count_out),
    .zero_flag    (zero_flag),
    .done_pulse   (done_pulse),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+2:0] model_vec();
    return {W'(m_count), (m_count == 0), m_done, (m_count != 0)};
  endfunction

  // Drive one edge of stimulus, advance the model, sample 1 time unit after the edge
  task automatic apply(input bit clr, input bit ld, input int lv, input bit en, input bit ar);
    clear        = clr;
    load         = ld;
    load_val     = W'(lv);
    count_enable = en;
    auto_reload  = ar;
    @(posedge clk);
    m_done = 1'b0;
    if (clr) begin
      m_count = 0;
    end else if (ld) begin
      m_count  = lv;
      m_reload = lv;
    end else if (en && m_count > 0) begin
      if (m_count == 1) begin
        m_done  = 1'b1;
        m_count = ar ? m_reload : 0;
      end else begin
        m_count = m_count - 1;
      end
    end
    #1;
    got = {count_out, zero_flag, done_pulse, busy};
    exp = model_vec();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 0; load = 0; load_val = '0; count_enable = 0; auto_reload = 0;
    m_count = 0; m_reload = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({count_out, zero_flag, done_pulse, busy} !== {W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_values: got cnt=%0d z=%0b d=%0b b=%0b exp cnt=0 z=1 d=0 b=0",
               count_out, zero_flag, done_pulse, busy);
    else passes++;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 1, 0);
      checks++;
      if (got !== {W'(0), 1'b1, 1'b0, 1'b0})
        $display("FAIL idle_enable[%0d]: got %h exp %h", i, got, {W'(0), 1'b1, 1'b0, 1'b0});
      else passes++;
    end
  endtask

  task automatic test_one_shot();
    int seq[6] = '{5, 4, 3, 2, 1, 0};
    apply(0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) apply(0, 0, 0, 1, 0);
      checks++;
      if (count_out !== W'(seq[i]) || done_pulse !== (i == 5) || busy !== (i != 5) ||
          zero_flag !== (i == 5) || got !== exp)
        $display("FAIL one_shot[%0d]: got %h exp cnt=%0d model %h", i, got, seq[i], exp);
      else passes++;
    end
    apply(0, 0, 0, 1, 0);
    checks++;
    if (got !== {W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL one_shot_after: got %h exp %h", got, {W'(0), 1'b1, 1'b0, 1'b0});
    else passes++;
  endtask

  task automatic test_periodic();
    int seq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int pulses = 0;
    apply(0, 1, 3, 0, 1);
    for (int i = 0; i < 9; i++) begin
      apply(0, 0, 0, 1, 1);
      if (done_pulse === 1'b1) pulses++;
      checks++;
      if (count_out !== W'(seq[i]) || done_pulse !== (seq[i] == 3) || busy !== 1'b1 ||
          zero_flag !== 1'b0 || got !== exp)
        $display("FAIL periodic[%0d]: got %h exp cnt=%0d model %h", i, got, seq[i], exp);
      else passes++;
    end
    checks++;
    if (pulses !== 3) $display("FAIL periodic_pulses: got %0d exp 3", pulses);
    else passes++;
  endtask

  task automatic test_edges();
    int pulses = 0;
    apply(0, 1, MAXV, 0, 0);
    for (int i = 0; i < MAXV; i++) begin
      apply(0, 0, 0, 1, 0);
      if (done_pulse === 1'b1) pulses++;
      if (i < MAXV - 1 && count_out === W'(0)) pulses += 100;
    end
    checks++;
    if (count_out !== W'(0) || pulses !== 1 || zero_flag !== 1'b1 || busy !== 1'b0)
      $display("FAIL max_period: got cnt=%0d pulses=%0d z=%0b b=%0b exp cnt=0 pulses=1 z=1 b=0",
               count_out, pulses, zero_flag, busy);
    else passes++;

    apply(0, 1, 0, 0, 0);
    checks++;
    if (got !== {W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL load_zero: got %h exp %h", got, {W'(0), 1'b1, 1'b0, 1'b0});
    else passes++;
    apply(0, 0, 0, 1, 1);
    checks++;
    if (got !== {W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL load_zero_enable: got %h exp %h", got, {W'(0), 1'b1, 1'b0, 1'b0});
    else passes++;

    apply(0, 1, 1, 0, 0);
    apply(0, 0, 0, 1, 0);
    checks++;
    if (got !== {W'(0), 1'b1, 1'b1, 1'b0})
      $display("FAIL load_one: got %h exp %h", got, {W'(0), 1'b1, 1'b1, 1'b0});
    else passes++;
  endtask

  task automatic test_priority();
    apply(0, 1, 6, 0, 0);
    apply(0, 0, 0, 1, 0);
    apply(0, 0, 0, 1, 0);
    checks++;
    if (count_out !== W'(4)) $display("FAIL prio_setup: got cnt=%0d exp cnt=4", count_out);
    else passes++;
    apply(1, 1, 9, 1, 0);
    checks++;
    if (got !== {W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL prio_clear: got %h exp %h", got, {W'(0), 1'b1, 1'b0, 1'b0});
    else passes++;
    apply(0, 1, 9, 1, 0);
    checks++;
    if (got !== {W'(9), 1'b0, 1'b0, 1'b1})
      $display("FAIL prio_load_over_enable: got %h exp %h", got, {W'(9), 1'b0, 1'b0, 1'b1});
    else passes++;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, 0);
      checks++;
      if (got !== {W'(9), 1'b0, 1'b0, 1'b1})
        $display("FAIL prio_hold[%0d]: got %h exp %h", i, got, {W'(9), 1'b0, 1'b0, 1'b1});
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    apply(0, 1, 9, 0, 1);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 1);
    checks++;
    if (count_out !== W'(6)) $display("FAIL arst_setup: got cnt=%0d exp cnt=6", count_out);
    else passes++;
    #2 n_rst = 1'b0;
    #1;
    m_count = 0; m_reload = 0; m_done = 0;
    checks++;
    if ({count_out, zero_flag, done_pulse, busy} !== {W'(0), 1'b1, 1'b0, 1'b0})
      $display("FAIL arst_immediate: got cnt=%0d z=%0b d=%0b b=%0b exp cnt=0 z=1 d=0 b=0",
               count_out, zero_flag, done_pulse, busy);
    else passes++;
    #1 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 1, 1);
      checks++;
      if (got !== {W'(0), 1'b1, 1'b0, 1'b0})
        $display("FAIL arst_no_restart[%0d]: got %h exp %h", i, got, {W'(0), 1'b1, 1'b0, 1'b0});
      else passes++;
    end
  endtask

  task automatic test_random();
    bit clr, ld, en, ar;
    int lv;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 24) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ar  = ($urandom_range(0, 1) == 1);
      lv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, MAXV));
      apply(clr, ld, lv, en, ar);
      checks++;
      if (got !== exp)
        $display("FAIL random[%0d]: got %h exp %h", i, got, exp);
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_edges();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/flex_down_counter.md
Name: flex_down_counter

Overview:
Parameterized loadable down-counter with terminal-count detection; the counting-down counterpart of the team's up-counting rollover counter.
Used as a bit/byte period timer and timeout generator: software or an FSM loads a period, the block counts it out and signals expiry.
Supports one-shot and auto-reload (periodic) operation.

Parameters:
NUM_CNT_BITS, 4, width of count, load value and internal reload register.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of count; highest synchronous priority.
load  input  1  synchronous load of load_val into count and reload register.
load_val  input  NUM_CNT_BITS  period value to load.
count_enable  input  1  decrement enable.
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled each cycle.
count_out  output  NUM_CNT_BITS  current count, registered.
zero_flag  output  1  registered; high while count_out == 0.
done_pulse  output  1  registered; single-cycle expiry strobe.
busy  output  1  registered; high while FSM is in RUN.

Behaviour:
- Reset (n_rst low, async): count_out=0, reload_reg=0, zero_flag=1, done_pulse=0, busy=0, state=IDLE. Reset mid-count abandons the count immediately, with no done_pulse.
- Synchronous priority per edge: clear > load > count_enable > hold.
- clear: count_out<=0, zero_flag<=1, done_pulse<=0, state<=IDLE. reload_reg is unchanged.
- load: count_out<=load_val, reload_reg<=load_val, done_pulse<=0. state<=RUN if load_val!=0, else IDLE. A load in the same cycle as count_enable loads without decrementing.
- FSM states: IDLE (count==0) and RUN (count!=0).
- IDLE: count_enable has no effect; count stays 0 and no done_pulse. auto_reload does not restart from IDLE; only load does.
- RUN with count_enable=1, count_out>1: count_out<=count_out-1, done_pulse<=0.
- RUN with count_enable=1, count_out==1:
  - done_pulse<=1 for exactly one cycle.
  - auto_reload=0: count_out<=0, state<=IDLE, zero_flag<=1.
  - auto_reload=1: count_out<=reload_reg, state stays RUN, zero_flag stays 0.
- RUN with count_enable=0: hold count and state; done_pulse<=0.
- Timing: done_pulse is high in the same cycle count_out first shows 0 (one-shot) or the reload value (periodic). Latency from the terminal enabled edge is 0 cycles of registered output.
- Period: a loaded value N with continuous enable expires after exactly N enabled edges. The maximum, load_val=2^NUM_CNT_BITS-1, must be exact. No wrap below 0 ever occurs.
- Width rules: all arithmetic is unsigned NUM_CNT_BITS; the decrement never underflows by construction.
- Output derivation: zero_flag and busy are registered, computed from next-state values, and consistent with count_out every cycle.

Decomposition:
- Shared package flex_pkg: enum typedef cnt_state_t {IDLE, RUN}; localparam for the default NUM_CNT_BITS.
- No sub-module: single always_ff state/count register block plus one always_comb next-state block.

Test Plan:
- Reset → count_out=0, zero_flag=1, done_pulse=0, busy=0; then count_enable=1 for 3 cycles → count stays 0, no done_pulse.
- One-shot: load_val=5, load 1 cycle, then enable → count_out 5,4,3,2,1,0; done_pulse high only in the cycle count_out=0; busy falls the same cycle; zero_flag=1 thereafter.
- Periodic: auto_reload=1, load 3, continuous enable for 9 edges → 2,1,3,2,1,3,2,1,3; done_pulse on each cycle count shows 3 after 1, three pulses total.
- Edge values:
  - load 15, 15 enabled edges → reaches 0 with one done_pulse.
  - load 0 → IDLE, zero_flag=1, no done_pulse.
  - load 1, one edge → 0 with done_pulse.
- Priority: at count 4 assert clear+load(9)+enable together → count 0; next cycle load(9)+enable → 9, not 8; drop enable for 5 cycles → holds 9, done_pulse=0.
- Async reset mid-count: at count 6, pulse n_rst low between edges → outputs immediately take reset values; after release, no done_pulse; reload_reg=0, so auto_reload alone does not restart.
